// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: the NOP word, tracker
// state encodings and the word-alignment helper.
package ifu_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_RUN  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_DROP = 2'd2
    } ifu_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// In-order instruction queue with flush; the head entry is read straight from
// the storage array, so a word written on edge N is visible in cycle N+1.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_wptr <= r_wptr + AW'(1);
            if (i_pop)
                r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage carries no reset; the empty case is masked at the top level.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush)
            r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC generation, single-outstanding request tracking
// against instruction memory, and an in-order queue feeding the if_id stage.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e    r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_req_addr;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    logic          w_req;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [63:0]   w_head;

    // Occupancy includes the response still in flight so a push never hits a full queue.
    assign w_occ   = {1'b0, w_count} + (CW+1)'(r_state == IFU_WAIT);
    assign w_req   = rst_n && !jump_en_i
                     && (r_state == IFU_RUN || imem_rvalid_i)
                     && (w_occ < (CW+1)'(FIFO_DEPTH));
    assign w_grant = w_req && imem_gnt_i;
    assign w_push  = imem_rvalid_i && (r_state == IFU_WAIT) && !jump_en_i;

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;

    assign w_empty      = (w_count == '0);
    assign inst_valid_o = !w_empty && !jump_en_i;
    assign w_pop        = inst_valid_o && inst_ready_i;
    assign inst_o       = w_empty ? INST_NOP : w_head[63:32];
    assign inst_addr_o  = w_empty ? 32'h0 : w_head[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IFU_RUN;
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
        end else begin
            if (jump_en_i)
                r_pc <= word_align(jump_addr_i);
            else if (w_grant)
                r_pc <= r_pc + 32'd4;

            if (w_grant)
                r_req_addr <= r_pc;

            // A fresh grant always defines the tracked response; otherwise a
            // returning response frees the tracker and a redirect poisons it.
            if (w_grant)
                r_state <= jump_en_i ? IFU_DROP : IFU_WAIT;
            else if (imem_rvalid_i && r_state != IFU_RUN)
                r_state <= IFU_RUN;
            else if (jump_en_i && r_state != IFU_RUN)
                r_state <= IFU_DROP;
        end
    end

    ifu_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (jump_en_i),
        .i_push  (w_push),
        .i_wdata ({imem_rdata_i, r_req_addr}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: memory responder, expected-stream scoreboard and directed
// plus randomized stimulus.
module tb_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_acc = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_tail;
    logic [63:0] mon_e;
    int          gnt_mode = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] a0;
    bit          found;

    ifu #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Expected program order: consecutive words from the latest start address.
    task automatic extend(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({mem_word(exp_tail), exp_tail});
            exp_tail = exp_tail + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        exp_tail = a & 32'hFFFF_FFFC;
        extend(64);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        jump_en_i = 1'b0;
        mem_cnt = 0;
        imem_rvalid_i = 1'b0;
        restart(32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        smp();
        while (!inst_valid_o && k < budget) begin
            smp();
            k++;
        end
        if (!inst_valid_o) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: no valid instruction within %0d cycles", name, budget);
        end
    endtask

    // Memory responder: one response per grant after a random latency.
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_cnt = 0;
            imem_rvalid_i = 1'b0;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            imem_rvalid_i = (mem_cnt == 0);
            imem_rdata_i = (mem_cnt == 0) ? mem_word(mem_addr) : $urandom;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i = $urandom;
        end
        if (gnt_mode == 0)
            imem_gnt_i = 1'b1;
        else if (gnt_mode == 1)
            imem_gnt_i = ($urandom_range(0, 9) < 7);
        else
            imem_gnt_i = 1'b0;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && imem_req_o && imem_gnt_i) begin
            mem_addr = imem_addr_o;
            mem_cnt = int'($urandom_range(lat_min, lat_max));
        end
    end

    // Scoreboard monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && inst_valid_o && inst_ready_i) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL stream extra: got addr %h with nothing expected", inst_addr_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("stream addr", inst_addr_o, mon_e[31:0]);
                chk("stream data", inst_o, mon_e[63:32]);
                if (exp_q.size() < 16)
                    extend(64);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values with a running clock
        gnt_mode = 0;
        inst_ready_i = 1'b1;
        restart(32'h0);
        repeat (3) smp();
        chk1("reset req", imem_req_o, 1'b0);
        chk1("reset valid", inst_valid_o, 1'b0);
        chk("reset inst", inst_o, NOP);
        chk("reset inst_addr", inst_addr_o, 32'h0);
        chk("reset imem_addr", imem_addr_o, 32'h0);
        tick();
        rst_n = 1'b1;
        smp();
        chk1("release req", imem_req_o, 1'b1);
        chk("release imem_addr", imem_addr_o, 32'h0);

        // Streaming, one per cycle
        wait_valid("stream start", 10);
        chk("stream0", inst_addr_o, 32'h0);
        smp(); chk("stream1", inst_addr_o, 32'h4);
        smp(); chk("stream2", inst_addr_o, 32'h8);
        smp(); chk("stream3", inst_addr_o, 32'hC);
        chk("stream3 word", inst_o, mem_word(32'hC));

        // Grant stall
        tick();
        gnt_mode = 2;
        tick();
        smp();
        a0 = imem_addr_o;
        smp(); chk("stall addr1", imem_addr_o, a0);
        smp(); chk("stall addr2", imem_addr_o, a0);
        tick();
        gnt_mode = 0;
        tick();
        smp();
        chk1("stall resume req", imem_req_o, 1'b1);
        chk("stall resume addr", imem_addr_o, a0);
        repeat (6) smp();

        // Backpressure
        inst_ready_i = 1'b0;
        do_reset();
        repeat (12) smp();
        chk1("bp valid", inst_valid_o, 1'b1);
        chk("bp head", inst_addr_o, 32'h0);
        chk1("bp req", imem_req_o, 1'b0);
        chk("bp imem_addr", imem_addr_o, 32'h10);
        tick();
        inst_ready_i = 1'b1;
        smp(); chk("drain0", inst_addr_o, 32'h0); chk1("drain0 req", imem_req_o, 1'b0);
        smp(); chk("drain1", inst_addr_o, 32'h4); chk1("drain1 req", imem_req_o, 1'b1);
        chk("drain1 imem_addr", imem_addr_o, 32'h10);
        smp(); chk("drain2", inst_addr_o, 32'h8);
        smp(); chk("drain3", inst_addr_o, 32'hC);
        smp(); chk("drain4", inst_addr_o, 32'h10);

        // Redirect with a fetch in flight
        lat_min = 2;
        lat_max = 2;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            smp();
            if (imem_req_o && imem_gnt_i && imem_addr_o == 32'h8)
                found = 1'b1;
        end
        n_chk++;
        if (!found) begin
            n_err++;
            $display("FAIL redirect grant8: no grant at address 8 within 20 cycles");
        end
        tick();
        jump_en_i = 1'b1;
        jump_addr_i = 32'h103;
        restart(32'h103);
        smp();
        chk1("jump valid", inst_valid_o, 1'b0);
        chk1("jump req", imem_req_o, 1'b0);
        tick();
        jump_en_i = 1'b0;
        smp();
        chk1("target req", imem_req_o, 1'b1);
        chk("target addr", imem_addr_o, 32'h100);
        wait_valid("target inst", 20);
        chk("target inst_addr", inst_addr_o, 32'h100);
        chk("target inst", inst_o, mem_word(32'h100));

        // Wrap and mid-run reset
        lat_min = 1;
        lat_max = 1;
        repeat (4) tick();
        jump_en_i = 1'b1;
        jump_addr_i = 32'hFFFF_FFFC;
        inst_ready_i = 1'b0;
        restart(32'hFFFF_FFFC);
        tick();
        jump_en_i = 1'b0;
        smp();
        chk("wrap addr0", imem_addr_o, 32'hFFFF_FFFC);
        smp();
        chk("wrap addr1", imem_addr_o, 32'h0);
        smp();
        smp();
        chk1("wrap valid", inst_valid_o, 1'b1);
        chk("wrap head", inst_addr_o, 32'hFFFF_FFFC);
        #1;
        rst_n = 1'b0;
        mem_cnt = 0;
        imem_rvalid_i = 1'b0;
        restart(32'h0);
        #1;
        chk1("midreset valid", inst_valid_o, 1'b0);
        chk1("midreset req", imem_req_o, 1'b0);
        chk("midreset inst", inst_o, NOP);
        chk("midreset inst_addr", inst_addr_o, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        smp();
        chk("post reset addr", imem_addr_o, 32'h0);

        // Randomized traffic with redirects
        inst_ready_i = 1'b1;
        gnt_mode = 1;
        lat_min = 1;
        lat_max = 3;
        n_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            inst_ready_i = ($urandom_range(0, 3) != 0);
            if (jump_en_i) begin
                jump_en_i = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                jump_addr_i = $urandom;
                jump_en_i = 1'b1;
                restart(jump_addr_i);
            end
        end
        jump_en_i = 1'b0;
        n_chk++;
        if (n_acc < 300) begin
            n_err++;
            $display("FAIL random progress: got %0d accepted instructions, required at least 300", n_acc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
